// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package mips_pkg;

  localparam int          DATA_W     = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          WORD_BYTES = 4;
  localparam int          FIFO_DEPTH = 2;

  typedef enum logic {
    FETCH = 1'b0,
    KILL  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory request/ack and decode-side valid/ready.
interface if_stage_if #(
  parameter int DATA_W = mips_pkg::DATA_W
);
  // imem: req/addr held from assertion through the cycle ack=1 is sampled;
  // ack may arrive in the same cycle as req. id: an entry transfers on any
  // cycle where id_valid & id_ready; id_valid never depends on id_ready.
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_inst;
  logic [DATA_W-1:0] id_pc_plus4;

  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc_plus4,
    input  imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc_plus4,
    output imem_ack, imem_rdata, id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry buffer of {inst, pc+4} between memory responses and decode.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int W = 2 * mips_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding memory request, redirect/kill FSM.
module if_stage
  import mips_pkg::*;
#(
  parameter int                DATA_W   = mips_pkg::DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  if_stage_if.master        bus,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] program_counter,
  output fetch_state_e      o_state
);

  fetch_state_e        r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_pc, w_pc_nxt;
  logic [DATA_W-1:0]   r_kill_addr, w_kill_addr_nxt;
  logic                r_out, w_out_nxt;
  logic [1:0]          w_count;
  logic                w_pop, w_push, w_flush, w_new, w_ack;
  logic [DATA_W-1:0]   w_target;
  logic [DATA_W-1:0]   w_pc_plus4;
  logic [2*DATA_W-1:0] w_head;

  assign w_target   = {redirect_pc[DATA_W-1:2], 2'b00};
  assign w_pc_plus4 = r_pc + DATA_W'(WORD_BYTES);
  assign w_pop      = bus.id_valid & bus.id_ready;
  // A fresh request may start when the slot it would fill is guaranteed free.
  assign w_new      = rst & (r_state == FETCH) & ~r_out &
                      ((w_count < 2'd2) | w_pop);
  assign w_ack      = bus.imem_req & bus.imem_ack;

  assign bus.imem_req  = r_out | w_new;
  assign bus.imem_addr = (r_state == KILL) ? r_kill_addr : r_pc;
  assign bus.id_valid  = (w_count != 2'd0);
  assign {bus.id_inst, bus.id_pc_plus4} = w_head;
  assign program_counter = r_pc;
  assign o_state         = r_state;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_kill_addr_nxt = r_kill_addr;
    w_out_nxt       = r_out;
    w_push          = 1'b0;
    w_flush         = 1'b0;
    case (r_state)
      FETCH: begin
        if (redirect) begin
          w_flush  = 1'b1;
          w_pc_nxt = w_target;
          // An unanswered request must still be honoured on the bus.
          if (bus.imem_req && !bus.imem_ack) begin
            w_state_nxt     = KILL;
            w_kill_addr_nxt = r_pc;
            w_out_nxt       = 1'b1;
          end else begin
            w_out_nxt = 1'b0;
          end
        end else if (w_ack) begin
          w_push    = 1'b1;
          w_pc_nxt  = w_pc_plus4;
          w_out_nxt = 1'b0;
        end else begin
          w_out_nxt = bus.imem_req;
        end
      end
      KILL: begin
        if (redirect) w_pc_nxt = w_target;
        if (bus.imem_ack) begin
          w_state_nxt = FETCH;
          w_out_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_kill_addr <= '0;
      r_out       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_kill_addr <= w_kill_addr_nxt;
      r_out       <= w_out_nxt;
    end
  end

  fetch_fifo #(.W(2 * DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  ({bus.imem_rdata, w_pc_plus4}),
    .o_data  (w_head),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory model with programmable latency, expected-entry queue.
module tb_if_stage;
  import mips_pkg::*;

  localparam int          W      = 64;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         redirect = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;
  logic [31:0]  program_counter;
  fetch_state_e o_state;

  if_stage_if #(.DATA_W(32)) bus ();

  if_stage #(.DATA_W(32), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus.master),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .program_counter (program_counter),
    .o_state         (o_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           pop_cyc[$];
  int           n_pops   = 0;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           mem_lat  = 0;
  int           rel_cyc  = 0;
  logic [W-1:0] mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [W-1:0] exp_entry(input logic [31:0] a);
    return {mem_word(a), a + 32'd4};
  endfunction

  // ---------------- memory model ----------------
  logic        mbusy = 1'b0;
  int          mwait = 0;
  logic [31:0] maddr = 32'h0;

  initial forever begin
    @(negedge rst);
    mbusy = 1'b0;
  end

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      #1;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'hDEAD_BEEF;
      if (!rst) begin
        mbusy = 1'b0;
      end else if (bus.imem_req) begin
        if (!mbusy) begin
          mbusy = 1'b1;
          mwait = 0;
          maddr = bus.imem_addr;
          check("imem_addr_align", bus.imem_addr[1:0], 2'b00);
        end else begin
          check("imem_addr_hold", bus.imem_addr, maddr);
        end
        if (mwait >= mem_lat) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(maddr);
          mbusy          = 1'b0;
        end else begin
          mwait++;
        end
      end else if (mbusy) begin
        check("imem_req_hold", bus.imem_req, 1'b1);
        mbusy = 1'b0;
      end
    end
  end

  // ---------------- decode-side monitor ----------------
  initial forever begin
    @(negedge clk);
    #2;
    if (rst && bus.id_valid && bus.id_ready) begin
      n_pops++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_id_valid", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("id_entry", {bus.id_inst, bus.id_pc_plus4}, mon_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_assert(input int lat);
    @(negedge clk);
    rst          = 1'b0;
    redirect     = 1'b0;
    bus.id_ready = 1'b0;
    mem_lat      = lat;
    exp_q.delete();
    #3;
    check("rst_imem_req", bus.imem_req, 1'b0);
    check("rst_id_valid", bus.id_valid, 1'b0);
    check("rst_id_inst", bus.id_inst, 32'h0);
    check("rst_id_pc4", bus.id_pc_plus4, 32'h0);
    check("rst_pc", program_counter, RST_PC);
    check("rst_state", o_state, FETCH);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst     = 1'b1;
    rel_cyc = cyc;
    #3;
    check("first_req", bus.imem_req, 1'b1);
    check("first_addr", bus.imem_addr, RST_PC);
  endtask

  task automatic wait_pops(input int n, input int budget);
    int p0;
    int k;
    p0 = n_pops;
    k  = 0;
    while ((n_pops - p0) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if ((n_pops - p0) < n) check("pop_timeout", n_pops - p0, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    bus.id_ready = 1'b0;

    // Zero-wait streaming: A,B,C,D back to back.
    reset_assert(0);
    bus.id_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_entry(32'(i * 4)));
    pop_cyc.delete();
    reset_release();
    wait_pops(4, 20);
    bus.id_ready = 1'b0;
    check("a_pop_count", pop_cyc.size(), 4);
    if (pop_cyc.size() >= 4) begin
      check("a_first_valid_cyc", pop_cyc[0] - rel_cyc, 1);
      check("a_back_to_back", pop_cyc[3] - pop_cyc[0], 3);
    end
    check("a_queue_drained", exp_q.size(), 0);

    // Decode stall: buffer saturates, fetch stops at PC 8.
    reset_assert(0);
    reset_release();
    repeat (5) @(negedge clk);
    #3;
    check("b_req_low", bus.imem_req, 1'b0);
    check("b_id_valid", bus.id_valid, 1'b1);
    check("b_pc", program_counter, 32'h8);
    check("b_head", {bus.id_inst, bus.id_pc_plus4}, exp_entry(32'h0));
    @(negedge clk);
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_entry(32'(i * 4)));
    bus.id_ready = 1'b1;
    wait_pops(3, 20);
    bus.id_ready = 1'b0;

    // Two-cycle memory, redirect while 0x4 is outstanding.
    begin
      logic found;
      reset_assert(2);
      bus.id_ready = 1'b1;
      exp_q.push_back(exp_entry(32'h0));
      reset_release();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        #3;
        if (bus.imem_req && bus.imem_addr == 32'h4) found = 1'b1;
      end
      check("c_req_at_4", found, 1'b1);
      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      @(negedge clk);
      redirect = 1'b0;
      exp_q.delete();
      exp_q.push_back(exp_entry(32'h40));
      exp_q.push_back(exp_entry(32'h44));
      #3;
      check("c_state_kill", o_state, KILL);
      check("c_pc_target", program_counter, 32'h40);
      check("c_kill_addr", bus.imem_addr, 32'h4);
      check("c_kill_req", bus.imem_req, 1'b1);
      wait_pops(2, 30);
      bus.id_ready = 1'b0;
    end

    // Redirect coincident with the very first ack; unaligned target.
    reset_assert(0);
    redirect    = 1'b1;
    redirect_pc = 32'h23;
    reset_release();
    @(negedge clk);
    redirect     = 1'b0;
    bus.id_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_entry(32'h20 + 32'(i * 4)));
    #3;
    check("d_pc", program_counter, 32'h20);
    check("d_addr", bus.imem_addr, 32'h20);
    check("d_req", bus.imem_req, 1'b1);
    check("d_no_stale", bus.id_valid, 1'b0);
    check("d_state", o_state, FETCH);
    wait_pops(2, 20);
    // Redirect while decode pops the head: that entry is still delivered.
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    @(negedge clk);
    redirect = 1'b0;
    exp_q.delete();
    exp_q.push_back(exp_entry(32'h80));
    exp_q.push_back(exp_entry(32'h84));
    #3;
    check("d_pc_80", program_counter, 32'h80);
    check("d_flushed", bus.id_valid, 1'b0);
    wait_pops(2, 20);
    bus.id_ready = 1'b0;

    // PC wrap at the top of the address space.
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    exp_q.delete();
    exp_q.push_back(exp_entry(32'hFFFF_FFFC));
    exp_q.push_back(exp_entry(32'h0));
    bus.id_ready = 1'b1;
    #3;
    check("e_pc", program_counter, 32'hFFFF_FFFC);
    check("e_addr", bus.imem_addr, 32'hFFFF_FFFC);
    wait_pops(2, 20);
    bus.id_ready = 1'b0;

    // Asynchronous reset in the middle of KILL.
    reset_assert(2);
    reset_release();
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    #3;
    check("f_state_kill", o_state, KILL);
    #1;
    rst = 1'b0;
    #1;
    check("f_rst_req", bus.imem_req, 1'b0);
    check("f_rst_valid", bus.id_valid, 1'b0);
    check("f_rst_inst", bus.id_inst, 32'h0);
    check("f_rst_pc4", bus.id_pc_plus4, 32'h0);
    check("f_rst_pc", program_counter, RST_PC);
    check("f_rst_state", o_state, FETCH);
    exp_q.delete();
    exp_q.push_back(exp_entry(RST_PC));
    exp_q.push_back(exp_entry(RST_PC + 32'd4));
    bus.id_ready = 1'b1;
    reset_release();
    wait_pops(2, 30);
    bus.id_ready = 1'b0;
    check("f_queue_drained", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
